// File: rtl/rf_sched_pkg.sv
// Shared widths and the MUL/DIV result payload for the register-file write scheduler.
package rf_sched_pkg;

  localparam int unsigned DW           = 32;
  localparam int unsigned AW           = 5;
  localparam int unsigned NREG         = 32;
  localparam int unsigned STARVE_LIMIT = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } md_entry_t;

endpackage

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO that holds MUL/DIV results until the RF write port is free.
module md_result_fifo
  import rf_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  md_entry_t       din,
  input  logic            pop,
  output md_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  md_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_write_sched.sv
// Shares the RF write port between WB and buffered MUL/DIV results, and raises
// the decode stall for registers with outstanding long-latency writes.
module rf_write_sched
  import rf_sched_pkg::*;
#(
  parameter int unsigned DW           = rf_sched_pkg::DW,
  parameter int unsigned AW           = rf_sched_pkg::AW,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = rf_sched_pkg::STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [AW-1:0]   md_addr,
  input  logic [DW-1:0]   md_data,
  input  logic            md_issue,
  input  logic [AW-1:0]   md_issue_addr,
  input  logic [AW-1:0]   id_ra0,
  input  logic [AW-1:0]   id_ra1,
  input  logic [AW-1:0]   id_wa,
  input  logic            id_we,
  output logic            stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd,
  output logic [NREG-1:0] busy_mask
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  md_entry_t        push_entry;
  md_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             wb_own;
  logic             drain;
  logic             haz;
  logic             starve_max;
  logic [SCW-1:0]   starve_cnt;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  clr_mask;
  logic [NREG-1:0]  set_mask;
  logic [NREG-1:0]  busy_eff;

  assign push_entry = '{addr: md_addr, data: md_data};

  md_result_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (md_valid),
    .din   (push_entry),
    .pop   (drain),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // WB always wins the port; the buffer drains only in WB bubbles (or WB to x0).
  assign wb_own   = wb_valid && (wb_addr != '0);
  assign drain    = !wb_own && !fifo_empty;
  assign md_ready = !fifo_full;
  assign rf_we    = wb_own || (drain && (head.addr != '0));
  assign rf_wa    = wb_own ? wb_addr : head.addr;
  assign rf_wd    = wb_own ? wb_data : head.data;

  // A register being drained this cycle is covered by RF write-through.
  assign clr_mask   = drain ? (NREG'(1) << head.addr) : '0;
  assign busy_eff   = busy & ~clr_mask;
  assign haz        = busy_eff[id_ra0] | busy_eff[id_ra1] | (id_we & busy_eff[id_wa]);
  assign starve_max = (starve_cnt == SCW'(STARVE_LIMIT));
  assign stall      = haz | starve_max;
  assign busy_mask  = busy;

  assign set_mask = (md_issue && (md_issue_addr != '0) && !stall)
                  ? (NREG'(1) << md_issue_addr) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      busy <= busy_eff | set_mask;
      if (drain) begin
        starve_cnt <= '0;
      end else if ((fifo_count != '0) && !starve_max) begin
        starve_cnt <= starve_cnt + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed and randomized checks of rf_write_sched against a queue-based model.
module tb_rf_write_sched;

  localparam int LIMIT = 8;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rstn;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_addr;
  logic [4:0]  id_ra0;
  logic [4:0]  id_ra1;
  logic [4:0]  id_wa;
  logic        id_we;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;

  rf_write_sched dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_addr       (md_addr),
    .md_data       (md_data),
    .md_issue      (md_issue),
    .md_issue_addr (md_issue_addr),
    .id_ra0        (id_ra0),
    .id_ra1        (id_ra1),
    .id_wa         (id_wa),
    .id_we         (id_we),
    .stall         (stall),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t       q[$];
  logic [31:0] m_busy;
  int          m_starve;
  int          checks;
  int          errors;

  logic        e_dr;
  ment_t       e_hd;
  logic        e_we;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;
  logic        e_stall;
  logic        e_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy   = '0;
    m_starve = 0;
  endtask

  // Expected combinational outputs from the model state and current inputs.
  task automatic model_comb();
    logic        own;
    logic [31:0] eff;
    own  = wb_valid && (wb_addr != 5'd0);
    e_dr = !own && (q.size() > 0);
    e_hd = '{a: 5'd0, d: 32'd0};
    if (q.size() > 0) e_hd = q[0];
    e_we = own || (e_dr && (e_hd.a != 5'd0));
    e_wa = own ? wb_addr : e_hd.a;
    e_wd = own ? wb_data : e_hd.d;
    eff = m_busy;
    if (e_dr) eff[e_hd.a] = 1'b0;
    e_stall = ((id_ra0 != 5'd0) && eff[id_ra0]) ||
              ((id_ra1 != 5'd0) && eff[id_ra1]) ||
              (id_we && (id_wa != 5'd0) && eff[id_wa]) ||
              (m_starve == LIMIT);
    e_ready = (q.size() < DEPTH);
  endtask

  task automatic model_update();
    int sz;
    sz = q.size();
    if (e_dr) begin
      m_busy[e_hd.a] = 1'b0;
      void'(q.pop_front());
    end
    if (md_issue && (md_issue_addr != 5'd0) && !e_stall) m_busy[md_issue_addr] = 1'b1;
    if (md_valid && e_ready) q.push_back('{a: md_addr, d: md_data});
    if (e_dr) m_starve = 0;
    else if (sz > 0) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
  endtask

  task automatic eval();
    #1;
    model_comb();
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("md_ready", 32'(md_ready), 32'(e_ready));
    check("stall", 32'(stall), 32'(e_stall));
    check("busy_mask", busy_mask, m_busy);
    if (e_we) begin
      check("rf_wa", 32'(rf_wa), 32'(e_wa));
      check("rf_wd", rf_wd, e_wd);
    end
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rstn) model_update();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    md_issue = 0; md_issue_addr = 0;
    id_ra0 = 0; id_ra1 = 0; id_wa = 0; id_we = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    eval();
    check("rst_busy", busy_mask, 32'd0);
    check("rst_ready", 32'(md_ready), 32'd1);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rstn = 1'b1;
    eval(); tick();

    // RAW on x5 resolved by a MUL result draining in a WB bubble
    idle(); md_issue = 1; md_issue_addr = 5; eval(); tick();
    idle(); id_ra0 = 5; eval();
    check("raw_stall", 32'(stall), 32'd1);
    check("raw_busy5", 32'(busy_mask[5]), 32'd1);
    tick();
    md_valid = 1; md_addr = 5; md_data = 32'h1234; eval();
    check("raw_stall_arrive", 32'(stall), 32'd1);
    tick();
    md_valid = 0; eval();
    check("raw_we", 32'(rf_we), 32'd1);
    check("raw_wa", 32'(rf_wa), 32'd5);
    check("raw_wd", rf_wd, 32'h1234);
    check("raw_nostall", 32'(stall), 32'd0);
    tick();
    eval(); check("raw_clr", 32'(busy_mask[5]), 32'd0); tick();

    // WB priority over a buffered x9 result
    idle(); wb_valid = 1; wb_addr = 1; wb_data = 32'h11;
    md_valid = 1; md_addr = 9; md_data = 32'h99; eval(); tick();
    md_valid = 0; wb_addr = 7; wb_data = 32'hAA; eval();
    check("pri_wa", 32'(rf_wa), 32'd7);
    check("pri_wd", rf_wd, 32'hAA);
    tick();
    idle(); eval();
    check("pri2_we", 32'(rf_we), 32'd1);
    check("pri2_wa", 32'(rf_wa), 32'd9);
    check("pri2_wd", rf_wd, 32'h99);
    tick();

    // Buffer full while WB holds the port
    idle(); wb_valid = 1; wb_addr = 1; wb_data = 32'h1;
    for (int i = 0; i < 2; i++) begin
      md_valid = 1; md_addr = 5'(2 + i); md_data = 32'h100 + 32'(i);
      eval(); check("full_ready1", 32'(md_ready), 32'd1); tick();
    end
    md_addr = 4; md_data = 32'h102;
    repeat (3) begin
      eval(); check("full_ready0", 32'(md_ready), 32'd0); tick();
    end
    wb_valid = 0; eval();
    check("full_prepop", 32'(md_ready), 32'd0);
    check("full_drain_wa", 32'(rf_wa), 32'd2);
    tick();
    eval();
    check("full_ready_again", 32'(md_ready), 32'd1);
    check("full_drain2_wa", 32'(rf_wa), 32'd3);
    tick();
    md_valid = 0; eval(); tick();
    eval(); tick();

    // Starvation forces a stall after LIMIT blocked cycles
    idle(); wb_valid = 1; wb_addr = 1; wb_data = 32'h5;
    md_valid = 1; md_addr = 6; md_data = 32'h66; eval(); tick();
    md_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      eval(); check("starve_low", 32'(stall), 32'd0); tick();
    end
    eval(); check("starve_high", 32'(stall), 32'd1); tick();
    eval(); check("starve_hold", 32'(stall), 32'd1); tick();
    wb_valid = 0; eval();
    check("starve_drain_we", 32'(rf_we), 32'd1);
    check("starve_drain_wa", 32'(rf_wa), 32'd6);
    check("starve_drain_stall", 32'(stall), 32'd1);
    tick();
    eval(); check("starve_fall", 32'(stall), 32'd0); tick();

    // x0 never becomes busy and its results pop without a write
    idle(); md_issue = 1; md_issue_addr = 0; eval(); tick();
    idle(); eval(); check("x0_busy", busy_mask, 32'd0);
    md_valid = 1; md_addr = 0; md_data = 32'hDEAD; tick();
    idle(); eval(); check("x0_we", 32'(rf_we), 32'd0);
    md_valid = 1; md_addr = 8; md_data = 32'h88; tick();
    idle(); eval();
    check("x0_next_we", 32'(rf_we), 32'd1);
    check("x0_next_wa", 32'(rf_wa), 32'd8);
    tick();

    // Reset in the middle of traffic
    idle(); wb_valid = 1; wb_addr = 1; md_valid = 1; md_addr = 3; md_data = 32'h33;
    md_issue = 1; md_issue_addr = 3; eval(); tick();
    md_addr = 4; md_issue_addr = 4; eval(); tick();
    idle(); rstn = 1'b0; model_reset(); eval();
    check("mrst_busy", busy_mask, 32'd0);
    check("mrst_ready", 32'(md_ready), 32'd1);
    check("mrst_we", 32'(rf_we), 32'd0);
    check("mrst_stall", 32'(stall), 32'd0);
    tick();
    rstn = 1'b1; eval();
    check("mrst_empty_we", 32'(rf_we), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      wb_valid      = ($urandom_range(0, 9) < 6);
      wb_addr       = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      md_valid      = ($urandom_range(0, 9) < 4);
      md_addr       = 5'($urandom_range(0, 7));
      md_data       = $urandom;
      md_issue      = ($urandom_range(0, 9) < 3);
      md_issue_addr = 5'($urandom_range(0, 7));
      id_ra0        = 5'($urandom_range(0, 7));
      id_ra1        = 5'($urandom_range(0, 7));
      id_wa         = 5'($urandom_range(0, 7));
      id_we         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        model_reset();
      end else begin
        rstn = 1'b1;
      end
      eval();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
